// File: rtl/rvvi_depacketizer.sv
// rvvi_depacketizer
//   Recovers fixed-width RVVI records from Ethernet frames arriving on an
//   AXI-stream receive channel. A frame is four header beats followed by
//   NW = ceil(RVVI_WIDTH/32) payload beats, the last of which carries tlast.
//   Frames with a wrong header or the wrong length are dropped and counted.
//
// Ports
//   m_axi_aclk, m_axi_aresetn  clock, asynchronous active-low reset
//   RvviAxiR*                  AXI-stream receive channel (tstrb ignored)
//   Rvvi, FrameCount           recovered record and its frame count
//   Valid / Ready              output handshake
//   FrameCountError            one-cycle pulse: frame count out of sequence
//   GoodFrames, DroppedFrames  saturating frame counters
//   dbg_state_o                current parser state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data stable until then; ready may
// depend combinationally on the consumer's ready (RvviAxiRready does).
module rvvi_depacketizer #(
  parameter int          RVVI_WIDTH        = 632,
  parameter int          FRAME_COUNT_WIDTH = 16,
  parameter logic [47:0] DST_MAC           = 48'h8F54_0000_1654,
  parameter logic [47:0] SRC_MAC           = 48'h4502_1111_6843,
  parameter logic [15:0] ETH_TYPE          = 16'h005c
) (
  input  logic                         m_axi_aclk,
  input  logic                         m_axi_aresetn,
  input  logic [31:0]                  RvviAxiRdata,
  input  logic [3:0]                   RvviAxiRstrb,
  input  logic                         RvviAxiRlast,
  input  logic                         RvviAxiRvalid,
  output logic                         RvviAxiRready,
  output logic [RVVI_WIDTH-1:0]        Rvvi,
  output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
  output logic                         Valid,
  input  logic                         Ready,
  output logic                         FrameCountError,
  output logic [15:0]                  GoodFrames,
  output logic [15:0]                  DroppedFrames,
  output logic [2:0]                   dbg_state_o
);

  localparam int NW = (RVVI_WIDTH + 31) / 32;
  localparam int SW = NW * 32;
  localparam int CW = $clog2(NW + 1);

  typedef enum logic [2:0] {
    HDR0    = 3'd0,
    HDR1    = 3'd1,
    HDR2    = 3'd2,
    HDR3    = 3'd3,
    PAYLOAD = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  state_t                         state_q, state_d, hdr_next;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [FRAME_COUNT_WIDTH-1:0]   fc_rx_q, fc_rx_d;
  logic [SW-1:0]                  sh_q, sh_next;
  logic [RVVI_WIDTH-1:0]          rvvi_q;
  logic [FRAME_COUNT_WIDTH-1:0]   fc_out_q, exp_q;
  logic                           valid_q, fce_q, first_q;
  logic [15:0]                    good_q, drop_q;
  logic                           beat, hdr_ok, accept, drop;

  assign RvviAxiRready = ~valid_q | Ready;
  assign beat          = RvviAxiRvalid & RvviAxiRready;

  // Payload beats enter at the top and move down, so after NW beats the
  // first payload word sits in bits [31:0].
  assign sh_next = (sh_q >> 32) | (SW'(RvviAxiRdata) << (SW - 32));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fc_rx_d  = fc_rx_q;
    accept   = 1'b0;
    drop     = 1'b0;
    hdr_ok   = 1'b0;
    hdr_next = HDR0;
    case (state_q)
      HDR0: begin
        hdr_ok   = (RvviAxiRdata == DST_MAC[31:0]);
        hdr_next = HDR1;
      end
      HDR1: begin
        hdr_ok   = (RvviAxiRdata == {SRC_MAC[15:0], DST_MAC[47:32]});
        hdr_next = HDR2;
      end
      HDR2: begin
        hdr_ok   = (RvviAxiRdata == SRC_MAC[47:16]);
        hdr_next = HDR3;
      end
      HDR3: begin
        hdr_ok   = (RvviAxiRdata[15:0] == ETH_TYPE);
        hdr_next = PAYLOAD;
      end
      default: ;
    endcase
    if (beat) begin
      case (state_q)
        HDR0, HDR1, HDR2, HDR3: begin
          // A header mismatch or an early tlast both end this frame's hope.
          drop = ~hdr_ok | RvviAxiRlast;
          if (RvviAxiRlast) begin
            state_d = HDR0;
          end else if (!hdr_ok) begin
            state_d = DRAIN;
          end else begin
            state_d = hdr_next;
            if (state_q == HDR3) begin
              fc_rx_d = RvviAxiRdata[31:16];
              cnt_d   = '0;
            end
          end
        end
        PAYLOAD: begin
          if (cnt_q == CW'(NW - 1)) begin
            if (RvviAxiRlast) begin
              accept  = 1'b1;
              state_d = HDR0;
            end else begin
              drop    = 1'b1;
              state_d = DRAIN;
            end
          end else if (RvviAxiRlast) begin
            drop    = 1'b1;
            state_d = HDR0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DRAIN: begin
          if (RvviAxiRlast) state_d = HDR0;
        end
        default: state_d = HDR0;
      endcase
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q <= HDR0;
      cnt_q   <= '0;
      fc_rx_q <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fc_rx_q <= fc_rx_d;
      if (beat && state_q == PAYLOAD) sh_q <= sh_next;
    end
  end

  // Output register, sequence tracking and counters. A new record can only
  // be accepted when RvviAxiRready is high, so a held record is never
  // overwritten before Ready.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      rvvi_q   <= '0;
      fc_out_q <= '0;
      valid_q  <= 1'b0;
      fce_q    <= 1'b0;
      first_q  <= 1'b1;
      exp_q    <= '0;
      good_q   <= '0;
      drop_q   <= '0;
    end else begin
      fce_q <= accept & ~first_q & (fc_rx_q != exp_q);
      if (accept) begin
        rvvi_q   <= sh_next[RVVI_WIDTH-1:0];
        fc_out_q <= fc_rx_q;
        valid_q  <= 1'b1;
        first_q  <= 1'b0;
        exp_q    <= fc_rx_q + 1'b1;
      end else if (Ready) begin
        valid_q <= 1'b0;
      end
      if (accept && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign Rvvi            = rvvi_q;
  assign FrameCount      = fc_out_q;
  assign Valid           = valid_q;
  assign FrameCountError = fce_q;
  assign GoodFrames      = good_q;
  assign DroppedFrames   = drop_q;
  assign dbg_state_o     = state_q;

  // tstrb carries no information here; padding bits above RVVI_WIDTH in the
  // last payload word are discarded.
  logic unused_strb;
  assign unused_strb = ^RvviAxiRstrb;
  generate
    if (SW > RVVI_WIDTH) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^sh_next[SW-1:RVVI_WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_rvvi_depacketizer.sv
module tb_rvvi_depacketizer;

  localparam int          RW  = 632;
  localparam int          NW  = (RW + 31) / 32;
  localparam logic [47:0] DST = 48'h8F54_0000_1654;
  localparam logic [47:0] SRC = 48'h4502_1111_6843;
  localparam logic [15:0] ETH = 16'h005c;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   RvviAxiRdata;
  logic [3:0]    RvviAxiRstrb;
  logic          RvviAxiRlast, RvviAxiRvalid, RvviAxiRready;
  logic [RW-1:0] Rvvi;
  logic [15:0]   FrameCount, GoodFrames, DroppedFrames;
  logic          Valid, Ready, FrameCountError;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  rvvi_depacketizer dut (
    .m_axi_aclk      (clk),
    .m_axi_aresetn   (rst_n),
    .RvviAxiRdata    (RvviAxiRdata),
    .RvviAxiRstrb    (RvviAxiRstrb),
    .RvviAxiRlast    (RvviAxiRlast),
    .RvviAxiRvalid   (RvviAxiRvalid),
    .RvviAxiRready   (RvviAxiRready),
    .Rvvi            (Rvvi),
    .FrameCount      (FrameCount),
    .Valid           (Valid),
    .Ready           (Ready),
    .FrameCountError (FrameCountError),
    .GoodFrames      (GoodFrames),
    .DroppedFrames   (DroppedFrames),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [15:0]   exp_fc_q[$];
  logic          exp_fce_q[$];
  int            m_good, m_drop;
  bit            m_first;
  logic [15:0]   m_expect;
  logic [31:0]   frame_q[$];

  task automatic model_reset();
    exp_q.delete();
    exp_fc_q.delete();
    exp_fce_q.delete();
    m_good   = 0;
    m_drop   = 0;
    m_first  = 1'b1;
    m_expect = 16'h0000;
  endtask

  // A frame is good exactly when its header words are the expected ones and
  // it is 4 + NW words long; anything else is one dropped frame.
  task automatic model_frame();
    bit            good;
    logic [31:0]   w;
    logic [RW-1:0] rec;
    logic [15:0]   fc;
    good = (frame_q.size() == 4 + NW);
    if (good) begin
      good = (frame_q[0] == DST[31:0]) && (frame_q[1] == {SRC[15:0], DST[47:32]}) &&
             (frame_q[2] == SRC[47:16]);
      w    = frame_q[3];
      good = good && (w[15:0] == ETH);
    end
    if (good) begin
      rec = '0;
      for (int k = 0; k < NW; k++) begin
        w = frame_q[4 + k];
        for (int b = 0; b < 32; b++)
          if (32 * k + b < RW) rec[32 * k + b] = w[b];
      end
      w  = frame_q[3];
      fc = w[31:16];
      exp_q.push_back(rec);
      exp_fc_q.push_back(fc);
      exp_fce_q.push_back(!m_first && (fc != m_expect));
      m_first  = 1'b0;
      m_expect = fc + 16'd1;
      if (m_good < 65535) m_good++;
    end else begin
      if (m_drop < 65535) m_drop++;
    end
  endtask

  // ---------------- compare process ----------------
  bit            cur_shown = 1'b0;
  bit            cur_bogus = 1'b0;
  logic [RW-1:0] cur_rvvi;
  logic [15:0]   cur_fc;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_shown = 1'b0;
    end else begin
      if (Valid) begin
        if (!cur_shown) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            cur_bogus = 1'b1;
            $display("FAIL unexpected_record: FrameCount %0h presented, none expected", FrameCount);
          end else begin
            cur_bogus = 1'b0;
            cur_rvvi  = exp_q.pop_front();
            cur_fc    = exp_fc_q.pop_front();
            chk("frame_count_error", RW'(FrameCountError), RW'(exp_fce_q.pop_front()));
          end
          cur_shown = 1'b1;
        end else begin
          chk("fce_quiet_hold", RW'(FrameCountError), '0);
        end
        if (!cur_bogus) begin
          chk("rvvi", Rvvi, cur_rvvi);
          chk("frame_count", RW'(FrameCount), RW'(cur_fc));
        end
        if (Ready) cur_shown = 1'b0;
      end else begin
        chk("fce_quiet_idle", RW'(FrameCountError), '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic build_frame(input logic [15:0] fc, input logic [15:0] etype,
                             input int npay, input logic [31:0] base);
    frame_q.delete();
    frame_q.push_back(DST[31:0]);
    frame_q.push_back({SRC[15:0], DST[47:32]});
    frame_q.push_back(SRC[47:16]);
    frame_q.push_back({fc, etype});
    for (int k = 0; k < npay; k++) frame_q.push_back(base + 32'(k));
  endtask

  // Called at posedge+1; returns at posedge+1 right after the beat's edge.
  task automatic wait_beat();
    int t = 0;
    bit rdy = 1'b0;
    while (!rdy) begin
      @(negedge clk);
      rdy = RvviAxiRready;
      @(posedge clk);
      #1;
      t++;
      if (!rdy && t > 200) begin
        n_checks++;
        $display("FAIL beat_timeout: RvviAxiRready %0b after %0d cycles, required 1", RvviAxiRready, t);
        rdy = 1'b1;
      end
    end
  endtask

  task automatic send_q(input bit use_model, input bit with_last);
    if (use_model) model_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      RvviAxiRdata  = frame_q[i];
      RvviAxiRlast  = with_last && (i == frame_q.size() - 1);
      RvviAxiRvalid = 1'b1;
      RvviAxiRstrb  = 4'($urandom_range(0, 15));
      wait_beat();
    end
    RvviAxiRvalid = 1'b0;
    RvviAxiRlast  = 1'b0;
  endtask

  task automatic send_good(input logic [15:0] fc, input logic [31:0] base);
    build_frame(fc, ETH, NW, base);
    send_q(1'b1, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", RW'(Valid), '0);
    chk("rst_fce", RW'(FrameCountError), '0);
    chk("rst_good", RW'(GoodFrames), '0);
    chk("rst_dropped", RW'(DroppedFrames), '0);
    chk("rst_frame_count", RW'(FrameCount), '0);
    chk("rst_rvvi", Rvvi, '0);
    model_reset();
    RvviAxiRvalid = 1'b0;
    RvviAxiRlast  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_good"}, RW'(GoodFrames), RW'(m_good));
    chk({tag, "_dropped"}, RW'(DroppedFrames), RW'(m_drop));
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] full_q[$];
  logic [31:0] lo_w;
  logic [23:0] hi_w;

  initial begin
    RvviAxiRdata  = '0;
    RvviAxiRstrb  = '0;
    RvviAxiRlast  = 1'b0;
    RvviAxiRvalid = 1'b0;
    Ready         = 1'b1;
    do_reset();
    chk("rst_axi_ready", RW'(RvviAxiRready), RW'(1));

    // Single good frame, count 5.
    send_good(16'h0005, 32'h1000_0000);
    lo_w = Rvvi[31:0];
    hi_w = Rvvi[RW-1:RW-24];
    chk("t1_valid", RW'(Valid), RW'(1));
    chk("t1_frame_count", RW'(FrameCount), RW'(16'h0005));
    chk("t1_rvvi_lo", RW'(lo_w), RW'(32'h1000_0000));
    chk("t1_rvvi_top", RW'(hi_w), RW'(24'h000013));
    chk("t1_good", RW'(GoodFrames), RW'(1));
    chk("t1_fce", RW'(FrameCountError), '0);
    @(posedge clk); #1;
    chk("t1_valid_one_cycle", RW'(Valid), '0);

    // Sequence gap 5 -> 7, then 8 in sequence.
    send_good(16'h0007, 32'h2000_0000);
    chk("t2_gap_fce", RW'(FrameCountError), RW'(1));
    send_good(16'h0008, 32'h2100_0000);
    chk("t2_inseq_fce", RW'(FrameCountError), '0);

    // Wrap FFFF -> 0000 is in sequence.
    send_good(16'hFFFF, 32'h3000_0000);
    send_good(16'h0000, 32'h3100_0000);
    chk("t3_wrap_fce", RW'(FrameCountError), '0);
    check_counters("t3");
    chk("t3_good_lit", RW'(GoodFrames), RW'(5));

    // Bad frames: wrong type, short, long; then a good one.
    do_reset();
    build_frame(16'h0010, 16'h0800, NW, 32'h4000_0000);
    send_q(1'b1, 1'b1);
    build_frame(16'h0010, ETH, 4, 32'h4100_0000);
    send_q(1'b1, 1'b1);
    build_frame(16'h0010, ETH, NW + 2, 32'h4200_0000);
    send_q(1'b1, 1'b1);
    send_good(16'h0010, 32'h4300_0000);
    @(posedge clk); #1;
    chk("t4_dropped_lit", RW'(DroppedFrames), RW'(3));
    chk("t4_good_lit", RW'(GoodFrames), RW'(1));
    check_counters("t4");

    // Backpressure: two frames with Ready low.
    Ready = 1'b0;
    send_good(16'h0011, 32'h5000_0000);
    @(negedge clk);
    chk("t5_axi_ready_low", RW'(RvviAxiRready), '0);
    chk("t5_valid_held", RW'(Valid), RW'(1));
    @(posedge clk); #1;
    fork
      send_good(16'h0012, 32'h5100_0000);
      begin
        repeat (10) @(posedge clk);
        #1 Ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("t5_queue_drained", RW'(exp_q.size()), '0);
    check_counters("t5");

    // Reset during payload beat 4, then the tail, then a good frame.
    build_frame(16'h0020, ETH, NW, 32'h6000_0000);
    full_q = frame_q;
    frame_q.delete();
    for (int i = 0; i < 8; i++) frame_q.push_back(full_q[i]);
    send_q(1'b0, 1'b0);
    RvviAxiRdata  = full_q[8];
    RvviAxiRvalid = 1'b1;
    do_reset();
    frame_q.delete();
    for (int i = 8; i < full_q.size(); i++) frame_q.push_back(full_q[i]);
    send_q(1'b1, 1'b1);
    chk("t6_tail_not_valid", RW'(Valid), '0);
    send_good(16'h0040, 32'h7000_0000);
    chk("t6_fce_after_reset", RW'(FrameCountError), '0);
    chk("t6_good_lit", RW'(GoodFrames), RW'(1));
    chk("t6_frame_count_lit", RW'(FrameCount), RW'(16'h0040));

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_drained", RW'(exp_q.size()), '0);
    check_counters("final");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rvvi_depacketizer.md
RVVI_DEPACKETIZER -- requirements
Module: rvvi_depacketizer

Interface
REQ-001 SHALL have parameter RVVI_WIDTH, default 632, giving the width of the recovered RVVI record in bits.
REQ-002 SHALL have parameter FRAME_COUNT_WIDTH, default 16, giving the frame-count width; the value is fixed at 16.
REQ-003 SHALL have parameters DST_MAC (default 48'h8F54_0000_1654), SRC_MAC (default 48'h4502_1111_6843) and ETH_TYPE (default 16'h005c), giving the accepted header values.
REQ-004 SHALL have port m_axi_aclk, input, 1 bit: the only clock; all state is updated on its rising edge.
REQ-005 SHALL have port m_axi_aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports RvviAxiRdata (input, 32), RvviAxiRstrb (input, 4), RvviAxiRlast (input, 1), RvviAxiRvalid (input, 1) and RvviAxiRready (output, 1): the AXI-stream receive channel from the Ethernet MAC.
REQ-007 SHALL have port Rvvi, output, RVVI_WIDTH bits: the recovered record.
REQ-008 SHALL have port FrameCount, output, 16 bits: the frame count of the record on Rvvi.
REQ-009 SHALL have ports Valid (output, 1) and Ready (input, 1): the output handshake.
REQ-010 SHALL have port FrameCountError, output, 1 bit: a one-cycle pulse flagging an out-of-sequence frame count.
REQ-011 SHALL have ports GoodFrames and DroppedFrames, outputs, 16 bits each: saturating frame counters.

Function
REQ-012 SHALL define a beat as a cycle in which RvviAxiRvalid and RvviAxiRready are both high; RvviAxiRstrb SHALL be ignored.
REQ-013 SHALL drive RvviAxiRready = ~Valid | Ready, combinationally.
REQ-014 SHALL parse the frame header in byte-lane order, with tdata[7:0] as the first byte:
  - beat0 = DST_MAC[31:0]
  - beat1 = {SRC_MAC[15:0], DST_MAC[47:32]}
  - beat2 = SRC_MAC[47:16]
  - beat3 = {FrameCount[15:0], ETH_TYPE}
REQ-015 SHALL treat the beats after the header as payload: NW = ceil(RVVI_WIDTH/32) beats, with payload beat k filling Rvvi[32k+31:32k]; bits above RVVI_WIDTH-1 in the last beat SHALL be discarded.
REQ-016 SHALL implement states HDR0, HDR1, HDR2, HDR3, PAYLOAD and DRAIN; reset state HDR0.
REQ-017 SHALL advance HDR0 -> HDR1 -> HDR2 -> HDR3 -> PAYLOAD, one beat per transition, when each header beat matches.
REQ-018 SHALL, on any header-beat mismatch, go to DRAIN, or to HDR0 if that beat carries tlast.
REQ-019 SHALL, in PAYLOAD, use a payload beat counter starting at 0 and incrementing per beat.
REQ-020 SHALL, in PAYLOAD, accept the frame when the beat with count NW-1 carries tlast: load Rvvi and FrameCount, set Valid the next cycle, increment GoodFrames, and return to HDR0.
REQ-021 SHALL treat tlast on any earlier beat, including header beats, as a short frame: drop it, increment DroppedFrames, return to HDR0.
REQ-022 SHALL treat a missing tlast on payload beat NW-1 as a long frame: drop it, increment DroppedFrames, go to DRAIN.
REQ-023 SHALL, in DRAIN, discard beats until tlast and then return to HDR0; each dropped frame SHALL increment DroppedFrames exactly once, at the moment it is dropped.
REQ-024 SHALL assemble the payload in a shift register separate from the Rvvi/FrameCount output register.
REQ-025 SHALL hold Valid high and keep Rvvi and FrameCount stable until Ready is high, then clear Valid, unless a new frame completes in the same cycle, in which case the new frame is loaded and Valid stays high.
REQ-026 SHALL hold a 16-bit expected count and a first-frame flag.
REQ-027 SHALL, on the first accepted frame after reset, pulse no FrameCountError.
REQ-028 SHALL, on each later accepted frame, pulse FrameCountError the cycle Valid rises if the received count differs from the expected count.
REQ-029 SHALL, on every accepted frame, set expected = received + 1 modulo 2^16, so that 16'hFFFF -> 16'h0000 is in sequence.
REQ-030 SHALL stop GoodFrames and DroppedFrames at 16'hFFFF rather than wrapping.

Reset
REQ-031 SHALL, while m_axi_aresetn is low, asynchronously force:
  - state HDR0, beat counter 0, first-frame flag set
  - Valid 0, FrameCountError 0, GoodFrames 0, DroppedFrames 0
  - Rvvi 0, FrameCount 0, expected count 0
REQ-032 SHALL, when reset asserts mid-frame, discard the partial frame without counting it; the remaining beats after release SHALL be handled per REQ-018.

Verification
REQ-033 SHALL be checked with a good frame: FrameCount 16'h0005 and payload words 32'h1000_0000+k, sent with Ready high -> Valid for exactly one cycle, FrameCount 16'h0005, Rvvi[31:0] 32'h1000_0000, GoodFrames 1, no FrameCountError.
REQ-034 SHALL be checked with a sequence gap: good frames with counts 5 then 7 -> FrameCountError on the second frame; a following frame with count 8 -> no error.
REQ-035 SHALL be checked with a wrap: counts 16'hFFFF then 16'h0000 -> no FrameCountError.
REQ-036 SHALL be checked with bad frames: ETH_TYPE 16'h0800, then tlast on payload beat 3, then a frame of NW+2 beats, then a good frame -> DroppedFrames 3, GoodFrames 1, only the last frame presented.
REQ-037 SHALL be checked with backpressure: Ready low while two good frames arrive -> RvviAxiRready low after the first completes, the first record held stable, and no beat of the second frame lost once Ready rises.
REQ-038 SHALL be checked with reset mid-frame: m_axi_aresetn low during payload beat 4 -> all outputs 0 immediately; the tail of that frame dropped, and a following good frame accepted with no FrameCountError.
